// File: rtl/mem_bus_controller_if.sv
// CPU-side request/response bundle for the byte-wide memory bus controller.
// The CPU is the master: it drives the request fields.
// The controller is the slave: it returns data, ready, err and busy.
interface mem_bus_controller_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic        cpu_err;
    logic        cpu_busy;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_err, cpu_busy
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_err, cpu_busy
    );
endinterface

// File: rtl/mem_bus_controller.sv
// Single-master controller between the CPU and the byte-wide ROM/RAM.
// Each access is sequenced as SETUP -> STROBE (1 + WAIT_STATES cycles) -> DONE.
// Every memory-side and CPU-side output comes straight from a register.
module mem_bus_controller #(
    parameter int unsigned WAIT_STATES  = 0,
    parameter logic [15:0] ROM_LIMIT    = 16'h7FFF,
    parameter bit          ROM_WRITABLE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_bus_controller_if.slave  cpu,
    output logic [15:0]          address_bus,
    inout  wire  [7:0]           data_bus,
    output logic                 rd_en,
    output logic                 wr_en,
    output logic                 rom_enable,
    output logic                 ram_enable
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_DONE
    } state_t;

    state_t      r_state;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic        r_we;
    logic        r_blocked;
    logic [3:0]  r_wait;
    logic        r_drive;
    logic        r_rd_en;
    logic        r_wr_en;
    logic        r_rom_en_n;
    logic        r_ram_en_n;
    logic [7:0]  r_rdata;
    logic        r_ready;
    logic        r_err;
    logic        r_busy;

    logic        w_is_rom;
    logic        w_blocked;
    logic [7:0]  w_data_in;

    // Region decode and write blocking are evaluated on the request fields so
    // they can be latched together with the address in the IDLE cycle.
    assign w_is_rom  = (cpu.cpu_addr <= ROM_LIMIT);
    assign w_blocked = cpu.cpu_we & w_is_rom & ~ROM_WRITABLE;
    assign w_data_in = data_bus;

    // NOTE: the bus is released with 'z rather than driven low; the memory
    // drives it during reads, and the controller only ever drives write data.
    assign data_bus = r_drive ? r_wdata : 8'hzz;

    assign address_bus   = r_addr;
    assign rd_en         = r_rd_en;
    assign wr_en         = r_wr_en;
    assign rom_enable    = r_rom_en_n;
    assign ram_enable    = r_ram_en_n;
    assign cpu.cpu_rdata = r_rdata;
    assign cpu.cpu_ready = r_ready;
    assign cpu.cpu_err   = r_err;
    assign cpu.cpu_busy  = r_busy;

    // Access sequencer: state, strobes, selects, bus drive and CPU responses.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register sees the pre-edge value of every other register.
        if (rst) begin
            // NOTE: reset is synchronous and covers every register, so an
            // aborted access leaves no strobe, select, drive or pulse behind.
            r_state    <= ST_IDLE;
            r_addr     <= 16'h0000;
            r_wdata    <= 8'h00;
            r_we       <= 1'b0;
            r_blocked  <= 1'b0;
            r_wait     <= 4'd0;
            r_drive    <= 1'b0;
            r_rd_en    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_rom_en_n <= 1'b1;
            r_ram_en_n <= 1'b1;
            r_rdata    <= 8'h00;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cpu.cpu_req) begin
                        r_addr     <= cpu.cpu_addr;
                        r_wdata    <= cpu.cpu_wdata;
                        r_we       <= cpu.cpu_we;
                        r_blocked  <= w_blocked;
                        r_drive    <= cpu.cpu_we;
                        r_rom_en_n <= ~w_is_rom;
                        r_ram_en_n <= w_is_rom;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_wait  <= 4'(WAIT_STATES);
                    r_rd_en <= ~r_we;
                    r_wr_en <= r_we & ~r_blocked;
                    r_state <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (r_wait == 4'd0) begin
                        r_rd_en <= 1'b0;
                        r_wr_en <= 1'b0;
                        r_ready <= 1'b1;
                        r_err   <= r_blocked;
                        if (!r_we) begin
                            r_rdata <= w_data_in;
                        end
                        r_state <= ST_DONE;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                ST_DONE: begin
                    // Select, address and write data were held for this
                    // hold-time cycle; release them as the access retires.
                    r_ready    <= 1'b0;
                    r_err      <= 1'b0;
                    r_drive    <= 1'b0;
                    r_rom_en_n <= 1'b1;
                    r_ram_en_n <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_controller.sv
// Directed bench for mem_bus_controller.
// dut0: WAIT_STATES=0, ROM writes blocked.  dut2: WAIT_STATES=2.
// Outputs are sampled 1 time unit after each rising edge.
module tb_mem_bus_controller;

    logic clk;
    logic rst;

    mem_bus_controller_if bus0 ();
    mem_bus_controller_if bus2 ();

    logic [15:0] addr0, addr2;
    tri1  [7:0]  data_bus0, data_bus2;
    logic        rd_en0, wr_en0, rom_en0, ram_en0;
    logic        rd_en2, wr_en2, rom_en2, ram_en2;

    int n_pass   = 0;
    int n_checks = 0;

    mem_bus_controller #(
        .WAIT_STATES (0),
        .ROM_LIMIT   (16'h7FFF),
        .ROM_WRITABLE(1'b0)
    ) dut0 (
        .clk        (clk),
        .rst        (rst),
        .cpu        (bus0),
        .address_bus(addr0),
        .data_bus   (data_bus0),
        .rd_en      (rd_en0),
        .wr_en      (wr_en0),
        .rom_enable (rom_en0),
        .ram_enable (ram_en0)
    );

    mem_bus_controller #(
        .WAIT_STATES (2),
        .ROM_LIMIT   (16'h7FFF),
        .ROM_WRITABLE(1'b1)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .cpu        (bus2),
        .address_bus(addr2),
        .data_bus   (data_bus2),
        .rd_en      (rd_en2),
        .wr_en      (wr_en2),
        .rom_enable (rom_en2),
        .ram_enable (ram_en2)
    );

    // ROM contents are a fixed function of the address: 0x0010 -> A5,
    // 0x0100 -> B5, 0x7FFF -> 4A.  dut2's RAM is also fixed: 0x8000 -> 96.
    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        return a[7:0] ^ 8'hB5;
    endfunction

    function automatic logic [7:0] ram2_byte(input logic [15:0] a);
        return a[7:0] ^ 8'h96;
    endfunction

    // dut0 memory model: writable RAM array, read-only ROM with a write flag.
    logic [7:0] ram0 [0:32767];
    logic       rom_written0;
    logic [7:0] mem_out0, mem_out2;

    assign mem_out0  = !rom_en0 ? rom_byte(addr0) : ram0[addr0[14:0]];
    assign data_bus0 = rd_en0 ? mem_out0 : 8'hzz;
    assign mem_out2  = !rom_en2 ? rom_byte(addr2) : ram2_byte(addr2);
    assign data_bus2 = rd_en2 ? mem_out2 : 8'hzz;

    always @(posedge clk) begin
        if (wr_en0 && !ram_en0) ram0[addr0[14:0]] <= data_bus0;
    end

    always @(posedge clk) begin
        if (rst)                     rom_written0 <= 1'b0;
        else if (wr_en0 && !rom_en0) rom_written0 <= 1'b1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1;
        bus0.cpu_req = 1'b0; bus0.cpu_we = 1'b0; bus0.cpu_addr = 16'h0; bus0.cpu_wdata = 8'h0;
        bus2.cpu_req = 1'b0; bus2.cpu_we = 1'b0; bus2.cpu_addr = 16'h0; bus2.cpu_wdata = 8'h0;
        tick();
        tick();

        // Reset values
        check("rst_rd_en",   rd_en0, 1'b0);
        check("rst_wr_en",   wr_en0, 1'b0);
        check("rst_rom_en",  rom_en0, 1'b1);
        check("rst_ram_en",  ram_en0, 1'b1);
        check("rst_addr",    addr0, 16'h0000);
        check("rst_bus_z",   data_bus0, 8'hFF);
        check("rst_rdata",   bus0.cpu_rdata, 8'h00);
        check("rst_ready",   bus0.cpu_ready, 1'b0);
        check("rst_err",     bus0.cpu_err, 1'b0);
        check("rst_busy",    bus0.cpu_busy, 1'b0);
        check("rst2_rom_en", rom_en2, 1'b1);
        check("rst2_busy",   bus2.cpu_busy, 1'b0);
        rst = 1'b0;
        tick();

        // 1: ROM read at 0x0010, no wait states
        bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b0; bus0.cpu_addr = 16'h0010;
        tick();
        bus0.cpu_req = 1'b0;
        check("t1_T1_rom_en", rom_en0, 1'b0);
        check("t1_T1_ram_en", ram_en0, 1'b1);
        check("t1_T1_rd_en",  rd_en0, 1'b0);
        check("t1_T1_addr",   addr0, 16'h0010);
        check("t1_T1_busy",   bus0.cpu_busy, 1'b1);
        tick();
        check("t1_T2_rd_en",  rd_en0, 1'b1);
        check("t1_T2_wr_en",  wr_en0, 1'b0);
        check("t1_T2_ready",  bus0.cpu_ready, 1'b0);
        tick();
        check("t1_T3_rd_en",  rd_en0, 1'b0);
        check("t1_T3_ready",  bus0.cpu_ready, 1'b1);
        check("t1_T3_err",    bus0.cpu_err, 1'b0);
        check("t1_T3_rdata",  bus0.cpu_rdata, 8'hA5);
        check("t1_T3_rom_en", rom_en0, 1'b0);
        check("t1_T3_ram_en", ram_en0, 1'b1);
        tick();
        check("t1_T4_ready",  bus0.cpu_ready, 1'b0);
        check("t1_T4_rom_en", rom_en0, 1'b1);
        check("t1_T4_busy",   bus0.cpu_busy, 1'b0);
        check("t1_T4_rdata",  bus0.cpu_rdata, 8'hA5);

        // 2: RAM write 0x3C to 0x8000, then read it back
        bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b1; bus0.cpu_addr = 16'h8000; bus0.cpu_wdata = 8'h3C;
        tick();
        bus0.cpu_req = 1'b0;
        check("t2_T1_ram_en", ram_en0, 1'b0);
        check("t2_T1_rom_en", rom_en0, 1'b1);
        check("t2_T1_bus",    data_bus0, 8'h3C);
        check("t2_T1_wr_en",  wr_en0, 1'b0);
        tick();
        check("t2_T2_wr_en",  wr_en0, 1'b1);
        check("t2_T2_rd_en",  rd_en0, 1'b0);
        check("t2_T2_bus",    data_bus0, 8'h3C);
        tick();
        check("t2_T3_wr_en",  wr_en0, 1'b0);
        check("t2_T3_ready",  bus0.cpu_ready, 1'b1);
        check("t2_T3_err",    bus0.cpu_err, 1'b0);
        check("t2_T3_bus",    data_bus0, 8'h3C);
        check("t2_T3_ram_en", ram_en0, 1'b0);
        tick();
        check("t2_T4_bus_z",  data_bus0, 8'hFF);
        check("t2_T4_ram_en", ram_en0, 1'b1);
        check("t2_T4_ready",  bus0.cpu_ready, 1'b0);
        bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b0; bus0.cpu_addr = 16'h8000;
        tick();
        bus0.cpu_req = 1'b0;
        tick();
        tick();
        check("t2_rb_ready",  bus0.cpu_ready, 1'b1);
        check("t2_rb_rdata",  bus0.cpu_rdata, 8'h3C);
        tick();

        // 3: blocked ROM write to 0x0100, then read original contents
        bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b1; bus0.cpu_addr = 16'h0100; bus0.cpu_wdata = 8'hFF;
        tick();
        bus0.cpu_req = 1'b0;
        check("t3_T1_rom_en", rom_en0, 1'b0);
        check("t3_T1_wr_en",  wr_en0, 1'b0);
        tick();
        check("t3_T2_wr_en",  wr_en0, 1'b0);
        check("t3_T2_rd_en",  rd_en0, 1'b0);
        check("t3_T2_rom_en", rom_en0, 1'b0);
        tick();
        check("t3_T3_wr_en",  wr_en0, 1'b0);
        check("t3_T3_ready",  bus0.cpu_ready, 1'b1);
        check("t3_T3_err",    bus0.cpu_err, 1'b1);
        tick();
        check("t3_T4_err",    bus0.cpu_err, 1'b0);
        check("t3_T4_ready",  bus0.cpu_ready, 1'b0);
        check("t3_rom_kept",  rom_written0, 1'b0);
        bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b0; bus0.cpu_addr = 16'h0100;
        tick();
        bus0.cpu_req = 1'b0;
        tick();
        tick();
        check("t3_rb_ready",  bus0.cpu_ready, 1'b1);
        check("t3_rb_err",    bus0.cpu_err, 1'b0);
        check("t3_rb_rdata",  bus0.cpu_rdata, 8'hB5);
        tick();

        // 4: two wait states, ROM read at the 0x7FFF boundary, then RAM at 0x8000
        bus2.cpu_req = 1'b1; bus2.cpu_we = 1'b0; bus2.cpu_addr = 16'h7FFF;
        tick();
        bus2.cpu_req = 1'b0;
        check("t4_T1_rom_en", rom_en2, 1'b0);
        check("t4_T1_ram_en", ram_en2, 1'b1);
        check("t4_T1_rd_en",  rd_en2, 1'b0);
        tick();
        check("t4_T2_rd_en",  rd_en2, 1'b1);
        tick();
        check("t4_T3_rd_en",  rd_en2, 1'b1);
        check("t4_T3_ready",  bus2.cpu_ready, 1'b0);
        tick();
        check("t4_T4_rd_en",  rd_en2, 1'b1);
        check("t4_T4_ready",  bus2.cpu_ready, 1'b0);
        tick();
        check("t4_T5_rd_en",  rd_en2, 1'b0);
        check("t4_T5_ready",  bus2.cpu_ready, 1'b1);
        check("t4_T5_rdata",  bus2.cpu_rdata, 8'h4A);
        tick();
        check("t4_T6_ready",  bus2.cpu_ready, 1'b0);
        check("t4_T6_busy",   bus2.cpu_busy, 1'b0);
        bus2.cpu_req = 1'b1; bus2.cpu_we = 1'b0; bus2.cpu_addr = 16'h8000;
        tick();
        bus2.cpu_req = 1'b0;
        check("t4_ram_en",    ram_en2, 1'b0);
        check("t4_ram_rom_en", rom_en2, 1'b1);
        tick();
        tick();
        tick();
        tick();
        check("t4_ram_ready", bus2.cpu_ready, 1'b1);
        check("t4_ram_rdata", bus2.cpu_rdata, 8'h96);
        tick();

        // 5: reset during STROBE of a RAM write
        bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b1; bus0.cpu_addr = 16'h8001; bus0.cpu_wdata = 8'h11;
        tick();
        bus0.cpu_req = 1'b0;
        tick();
        check("t5_T2_wr_en",  wr_en0, 1'b1);
        rst = 1'b1;
        tick();
        check("t5_wr_en",     wr_en0, 1'b0);
        check("t5_rom_en",    rom_en0, 1'b1);
        check("t5_ram_en",    ram_en0, 1'b1);
        check("t5_bus_z",     data_bus0, 8'hFF);
        check("t5_busy",      bus0.cpu_busy, 1'b0);
        check("t5_ready",     bus0.cpu_ready, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_no_ready", bus0.cpu_ready, 1'b0);
        end

        // 6: requests during an ongoing read are ignored; a new one at T4 is taken
        bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b0; bus0.cpu_addr = 16'h0010;
        tick();
        bus0.cpu_we = 1'b1; bus0.cpu_addr = 16'h8000; bus0.cpu_wdata = 8'hEE;
        tick();
        check("t6_T2_addr",   addr0, 16'h0010);
        check("t6_T2_rd_en",  rd_en0, 1'b1);
        check("t6_T2_ready",  bus0.cpu_ready, 1'b0);
        tick();
        bus0.cpu_req = 1'b0;
        check("t6_T3_ready",  bus0.cpu_ready, 1'b1);
        check("t6_T3_rdata",  bus0.cpu_rdata, 8'hA5);
        check("t6_T3_addr",   addr0, 16'h0010);
        check("t6_T3_wr_en",  wr_en0, 1'b0);
        tick();
        check("t6_T4_ready",  bus0.cpu_ready, 1'b0);
        check("t6_T4_busy",   bus0.cpu_busy, 1'b0);
        bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b0; bus0.cpu_addr = 16'h0100;
        tick();
        bus0.cpu_req = 1'b0;
        check("t6_T5_busy",   bus0.cpu_busy, 1'b1);
        check("t6_T5_addr",   addr0, 16'h0100);
        check("t6_T5_rom_en", rom_en0, 1'b0);
        tick();
        tick();
        check("t6_new_ready", bus0.cpu_ready, 1'b1);
        check("t6_new_rdata", bus0.cpu_rdata, 8'hB5);
        tick();
        check("t6_end_ready", bus0.cpu_ready, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_controller.md
Name: mem_bus_controller

Overview:
Single-master memory bus controller between the CPU core and the byte-wide external memories: the 32K ROM and the RAM.
- Accepts one CPU byte request at a time and decodes the address to a region.
- Sequences chip select and the read/write strobes through a registered SETUP / STROBE / DONE cycle with programmable wait states.
- Owns the shared tri-state data bus and returns read data with a one-cycle ready pulse.

Parameters:
WAIT_STATES, 0, extra STROBE cycles per access (legal 0..15).
ROM_LIMIT, 16'h7FFF, highest ROM address; addresses above it select RAM.
ROM_WRITABLE, 1, 1 = ROM writes permitted (simulation load), 0 = ROM writes blocked and flagged.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
cpu_req  input  1  request strobe, sampled only in IDLE
cpu_we  input  1  1 = write, 0 = read; sampled with cpu_req
cpu_addr  input  16  byte address; sampled with cpu_req
cpu_wdata  input  8  write data; sampled with cpu_req
cpu_rdata  output  8  read data; valid when cpu_ready=1, holds until next read completes
cpu_ready  output  1  one-cycle completion pulse
cpu_err  output  1  one-cycle pulse coincident with cpu_ready on a blocked ROM write
cpu_busy  output  1  1 whenever state != IDLE
address_bus  output  16  registered memory address
data_bus  inout  8  shared memory data bus
rd_en  output  1  read strobe, active high
wr_en  output  1  write strobe, active high
rom_enable  output  1  ROM select, active low
ram_enable  output  1  RAM select, active low

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All memory-side outputs and cpu_* outputs are registered.
- Reset values:
  - state IDLE
  - rd_en=0, wr_en=0, rom_enable=1, ram_enable=1
  - address_bus=0, data_bus high-Z
  - cpu_rdata=0, cpu_ready=0, cpu_err=0, cpu_busy=0
- Region decode on the latched address: cpu_addr <= ROM_LIMIT selects ROM; otherwise RAM. Exactly one select is low from SETUP through DONE; both are high in IDLE.
- blocked = we & ROM region & (ROM_WRITABLE==0).
- States: IDLE -> SETUP -> STROBE -> DONE -> IDLE. Let T0 be the cycle in which cpu_req is sampled high in IDLE.
  - IDLE: on cpu_req=1, latch addr/we/wdata/region/blocked; next state SETUP. Otherwise stay.
  - SETUP (T1):
    - address_bus = latched addr; selected enable low; strobes 0.
    - For writes, data_bus is driven with wdata.
  - STROBE (T2 .. T2+WAIT_STATES):
    - rd_en=1 for reads; wr_en=1 for non-blocked writes; blocked writes assert no strobe.
    - A 4-bit wait counter is loaded with WAIT_STATES on entry and decrements each cycle; exit when it reaches 0.
    - Reads: cpu_rdata captures data_bus on the last STROBE cycle.
  - DONE (T3+WAIT_STATES):
    - Strobes 0; select and address held (hold time); write data still driven.
    - cpu_ready=1, and cpu_err=blocked.
    - Next state IDLE.
- Timing:
  - Latency from request sample to ready = WAIT_STATES+3 cycles.
  - Minimum request spacing = WAIT_STATES+4 cycles.
- Requests: cpu_req while cpu_busy=1 is ignored (not queued). The CPU must re-request after ready.
- Data-bus ownership:
  - The controller drives data_bus only for write transactions (SETUP, STROBE, DONE); high-Z at all other times.
  - The controller must never drive data_bus while rd_en=1.
  - rd_en and wr_en are never both 1.
- Address boundaries: 16'h7FFF selects ROM; 16'h8000 selects RAM; 16'hFFFF selects RAM. No wrap logic is needed.
- Reset mid-operation: on the edge where rst=1, return to IDLE with all reset values. Strobes drop, the bus goes high-Z, and no cpu_ready or cpu_err is produced for the aborted access.
- rst has priority over cpu_req in the same cycle.

Test Plan:
1. ROM read, WAIT_STATES=0, cpu_addr=16'h0010, ROM model holds 8'hA5 -> rom_enable low T1-T3, rd_en=1 in T2 only, cpu_ready pulse at T3, cpu_rdata=8'hA5, ram_enable stays 1.
2. RAM write, cpu_addr=16'h8000, cpu_wdata=8'h3C -> ram_enable low T1-T3, wr_en=1 in T2, data_bus=8'h3C T1-T3 then Z, cpu_err=0, readback of 16'h8000 returns 8'h3C.
3. ROM write with ROM_WRITABLE=0, cpu_addr=16'h0100, data 8'hFF -> wr_en never asserted, cpu_ready and cpu_err both 1 at T3, subsequent read of 16'h0100 returns original contents.
4. WAIT_STATES=2 read at 16'h7FFF -> ROM selected, rd_en=1 T2-T4, cpu_ready at T5; then read at 16'h8000 selects RAM.
5. Assert rst during STROBE of a write -> next cycle wr_en=0, both enables 1, data_bus Z, cpu_ready never pulses, cpu_busy=0.
6. Pulse cpu_req at T1 and T2 of an ongoing read -> ignored; exactly one cpu_ready; a new request at T4 is accepted with normal timing.
